// File: rtl/sram_like_slave.sv
// In-order sram-like bus responder in front of a single-port synchronous RAM.
// Responses are buffered in a circular FIFO whose occupancy is bounded by the outstanding count.
module sram_like_slave #(
  parameter int ADDR_W  = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  input  logic              req_stall,
  input  logic              resp_stall,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  logic [CW-1:0] cnt;
  logic          p_v;
  logic          p_wr;
  logic [31:0]   fifo [MAX_OUT];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          accept;
  logic          fifo_nonempty;
  logic          unused_bits;

  assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_W+2]};

  // Slot availability looks only at the registered count, so a same-cycle pop frees nothing yet.
  assign addr_ok       = !reset && !req_stall && (cnt < CW'(MAX_OUT));
  assign accept        = req && addr_ok;
  assign fifo_nonempty = (wr_ptr != rd_ptr);
  assign data_ok       = !reset && !resp_stall && fifo_nonempty;
  assign rdata         = (!reset && fifo_nonempty) ? fifo[rd_ptr[PW-1:0]] : 32'h0;

  assign ram_en    = accept;
  assign ram_we    = (accept && wr) ? wstrb : 4'b0000;
  assign ram_addr  = accept ? addr[ADDR_W+1:2] : {ADDR_W{1'b0}};
  assign ram_wdata = accept ? wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept && !data_ok) begin
      cnt <= cnt + CW'(1);
    end else if (!accept && data_ok) begin
      cnt <= cnt - CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_v  <= 1'b0;
      p_wr <= 1'b0;
    end else begin
      p_v  <= accept;
      p_wr <= accept ? wr : 1'b0;
    end
  end

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (p_v) begin
        wr_ptr <= wr_ptr + CW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (data_ok) begin
        rd_ptr <= rd_ptr + CW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (p_v && !reset) begin
      fifo[wr_ptr[PW-1:0]] <= p_wr ? 32'h0 : ram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: a cycle table for the basic traffic plus
// hand-written sequences for full/stall, simultaneous pop/accept and mid-flight reset.
module tb_sram_like_slave;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        req_stall;
  logic        resp_stall;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [31:0] pl_data;

  int total;
  int bad;

  sram_like_slave #(.ADDR_W(16), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .req_stall(req_stall), .resp_stall(resp_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte-enabled RAM with a backdoor preload port.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        rqs;
    logic        rss;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        ren;
    logic [3:0]  rwe;
    logic [15:0] raddr;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    logic [31:0] exp_cnt [6];
    total = 0; bad = 0;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'h0;
    wstrb = 4'h0; wdata = 32'h0; req_stall = 1'b0; resp_stall = 1'b0;
    pl_en = 1'b0; pl_addr = 16'h0; pl_data = 32'h0;

    //         req  wr    addr        wstrb    wdata          rqs   rss   aok   dok   rdata          ren   rwe      raddr    cnt
    vt[0]  = '{1'b1, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 4'b0000, 16'h40, 3'd0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 16'h0,  3'd1};
    vt[2]  = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 4'b0000, 16'h0,  3'd1};
    vt[3]  = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 16'h0,  3'd0};
    vt[4]  = '{1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 4'b0000, 16'h0,  3'd0};
    vt[5]  = '{1'b1, 1'b0, 32'h4,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 4'b0000, 16'h1,  3'd1};
    vt[6]  = '{1'b1, 1'b0, 32'h8,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h1,        1'b1, 4'b0000, 16'h2,  3'd2};
    vt[7]  = '{1'b1, 1'b0, 32'hC,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h2,        1'b1, 4'b0000, 16'h3,  3'd2};
    vt[8]  = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h3,        1'b0, 4'b0000, 16'h0,  3'd2};
    vt[9]  = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h4,        1'b0, 4'b0000, 16'h0,  3'd1};
    vt[10] = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 16'h0,  3'd0};
    vt[11] = '{1'b1, 1'b1, 32'h40,  4'b0011, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 4'b0011, 16'h10, 3'd0};
    vt[12] = '{1'b1, 1'b0, 32'h40,  4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 4'b0000, 16'h10, 3'd1};
    vt[13] = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 4'b0000, 16'h0,  3'd2};
    vt[14] = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h1122CCDD, 1'b0, 4'b0000, 16'h0,  3'd1};
    vt[15] = '{1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000, 16'h0,  3'd0};
    vt[16] = '{1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'b0000, 16'h0,  3'd0};

    load(16'h40, 32'h12345678);
    load(16'h0, 32'h1);
    load(16'h1, 32'h2);
    load(16'h2, 32'h3);
    load(16'h3, 32'h4);
    load(16'h4, 32'h5);
    load(16'h10, 32'h11223344);

    // Reset state, with a request presented during reset.
    req = 1'b1; wr = 1'b1; wstrb = 4'hF; wdata = 32'hDEADBEEF; addr = 32'h20;
    @(negedge clk);
    chk("rst_addr_ok", 32'(addr_ok), 32'h0);
    chk("rst_data_ok", 32'(data_ok), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    next_cycle();
    reset = 1'b0; req = 1'b0; wr = 1'b0; wstrb = 4'h0; wdata = 32'h0; addr = 32'h0;

    for (int i = 0; i < 17; i++) begin
      req = vt[i].req; wr = vt[i].wr; addr = vt[i].addr; wstrb = vt[i].wstrb;
      wdata = vt[i].wdata; req_stall = vt[i].rqs; resp_stall = vt[i].rss;
      @(negedge clk);
      chk($sformatf("v%0d_addr_ok", i), 32'(addr_ok), 32'(vt[i].aok));
      chk($sformatf("v%0d_data_ok", i), 32'(data_ok), 32'(vt[i].dok));
      if (vt[i].dok) chk($sformatf("v%0d_rdata", i), rdata, vt[i].rdata);
      chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vt[i].ren));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].rwe));
      if (vt[i].ren) chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].raddr));
      if (vt[i].ren && vt[i].wr) chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vt[i].wdata);
      chk($sformatf("v%0d_cnt", i), 32'(dut.cnt), 32'(vt[i].cnt));
      next_cycle();
    end

    // Fill to MAX_OUT with responses held back.
    k = 0;
    req = 1'b1; wr = 1'b0; addr = 32'h0; req_stall = 1'b0; resp_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("full%0d_addr_ok", i), 32'(addr_ok), 32'(i < 4));
      chk($sformatf("full%0d_data_ok", i), 32'(data_ok), 32'h0);
      chk($sformatf("full%0d_cnt", i), 32'(dut.cnt), (i < 4) ? 32'(i) : 32'd4);
      if (addr_ok) k++;
      next_cycle();
      addr = 32'(k) << 2;
    end

    // Release: pop and request collide at cnt=MAX_OUT; the slot frees one cycle later.
    exp_cnt = '{32'd4, 32'd3, 32'd3, 32'd2, 32'd1, 32'd0};
    resp_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rel%0d_data_ok", i), 32'(data_ok), 32'(i < 5));
      if (i < 5) chk($sformatf("rel%0d_rdata", i), rdata, 32'(i + 1));
      if (i < 2) chk($sformatf("rel%0d_addr_ok", i), 32'(addr_ok), 32'(i == 1));
      chk($sformatf("rel%0d_cnt", i), 32'(dut.cnt), exp_cnt[i]);
      next_cycle();
      if (i == 1) req = 1'b0;
    end

    // Reset with three reads buffered behind resp_stall.
    resp_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; addr = 32'(i) << 2;
      next_cycle();
    end
    req = 1'b0;
    next_cycle();
    reset = 1'b1; req = 1'b1; addr = 32'h0;
    @(negedge clk);
    chk("mrst_addr_ok", 32'(addr_ok), 32'h0);
    chk("mrst_data_ok", 32'(data_ok), 32'h0);
    chk("mrst_ram_en", 32'(ram_en), 32'h0);
    chk("mrst_rdata", rdata, 32'h0);
    next_cycle();
    reset = 1'b0; resp_stall = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post%0d_data_ok", i), 32'(data_ok), 32'h0);
      if (i == 0) chk("post_addr_ok", 32'(addr_ok), 32'h1);
      if (i == 0) chk("post_cnt", 32'(dut.cnt), 32'h0);
      next_cycle();
    end
    req = 1'b1; addr = 32'h100;
    @(negedge clk);
    chk("new_addr_ok", 32'(addr_ok), 32'h1);
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    chk("new_data_ok_t1", 32'(data_ok), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("new_data_ok_t2", 32'(data_ok), 32'h1);
    chk("new_rdata", rdata, 32'h12345678);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
